// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: FSM states, owner encoding
// and default bus widths.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE,
      RESP
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Winner select between fetch and load/store requesters. Fixed DM priority with a
// starvation guard by default; ARB_ROUND_ROBIN_EN swaps in alternating priority.
module arb_pick
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
`ifdef ARB_ROUND_ROBIN_EN
   input  owner_t last_owner,
`else
   input  logic   clk,
   input  logic   reset,
   input  logic   grant,
`endif
   input  logic   if_req,
   input  logic   dm_req,
   output owner_t win
);

`ifdef ARB_ROUND_ROBIN_EN
   // The previous winner drops to low priority when both ask.
   always_comb begin
      win = OWN_DM;
      if (if_req && dm_req)
         win = (last_owner == OWN_DM) ? OWN_IF : OWN_DM;
      else if (if_req)
         win = OWN_IF;
   end
`else
   localparam int SC_W = $clog2(STARVE_MAX + 2);

   logic [SC_W-1:0] starve_cnt;

   always_comb begin
      win = OWN_DM;
      if (if_req && (!dm_req || starve_cnt == SC_W'(STARVE_MAX)))
         win = OWN_IF;
   end

   // Counts DM wins that left a fetch waiting; any fetch win clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (win == OWN_IF)
            starve_cnt <= '0;
         else if (if_req)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified memory sequencer for the CPU: one command at a time, fixed
// latency, response routed back to the owner. ARB_ROUND_ROBIN_EN selects the arbiter flavour.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int              LC_W     = $clog2(MEM_LAT + 1);
   localparam logic [LC_W-1:0] LAT_LOAD = LC_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

   state_t          state;
   owner_t          owner;
   owner_t          win;
   logic [LC_W-1:0] lat_cnt;
   logic            is_store;
   logic            take;

   assign take = (state == IDLE) && (if_req || dm_req);

   arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
`ifdef ARB_ROUND_ROBIN_EN
      .last_owner (owner),
`else
      .clk        (clk),
      .reset      (reset),
      .grant      (take),
`endif
      .if_req     (if_req),
      .dm_req     (dm_req),
      .win        (win)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_IF;
         lat_cnt   <= '0;
         is_store  <= 1'b0;
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         case (state)
            IDLE: begin
               if (take) begin
                  state  <= ISSUE;
                  busy   <= 1'b1;
                  owner  <= win;
                  mem_en <= 1'b1;
                  if (win == OWN_DM) begin
                     dm_gnt    <= 1'b1;
                     mem_we    <= dm_we;
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     is_store  <= dm_we;
                  end else begin
                     if_gnt    <= 1'b1;
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     is_store  <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               lat_cnt <= LAT_LOAD;
               state   <= (MEM_LAT > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
               if (lat_cnt == '0)
                  state <= CAPTURE;
               else
                  lat_cnt <= lat_cnt - 1'b1;
            end
            // mem_rdata is valid in this cycle; stores ack with zero data.
            CAPTURE: begin
               state <= RESP;
               if (owner == OWN_IF) begin
                  if_rvalid <= 1'b1;
                  if_rdata  <= mem_rdata;
               end else begin
                  dm_rvalid <= 1'b1;
                  dm_rdata  <= is_store ? '0 : mem_rdata;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference
// model, plus a short MEM_LAT = 1 fetch run on a second instance.
module tb_mem_port_arbiter;

   localparam int LAT    = 2;
   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
   logic        mem_en, mem_we, busy;
   logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        if_req1, if_gnt1, if_rvalid1, dm_req1, dm_we1, dm_gnt1, dm_rvalid1;
   logic        mem_en1, mem_we1, busy1;
   logic [31:0] if_addr1, if_rdata1, dm_addr1, dm_wdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(STARVE)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(STARVE)) u_lat1 (
      .clk(clk), .reset(reset),
      .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
      .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
      .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .busy(busy1)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // requester state (held until granted)
   bit          if_pend, dm_pend, dm_we_r;
   logic [31:0] if_a, dm_a, dm_d;
   // reference schedule of the current transaction
   int          gnt_cyc = -100;
   int          next_idle = -1;
   bit          win_dm, last_dm;
   int          starve;
   bit          t_we;
   logic [31:0] t_addr, t_wdata, t_rdata;
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] bus_mem [logic [31:0]];
   int          resp_cyc = -100;
   logic [31:0] resp_data;
   int          rst_left, p_if, p_dm, p_we, p_rst;
   bit          force_rst;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'h100 + ($urandom_range(0, 15) << 2);
   endfunction

   task automatic chk_zero();
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
   endtask

   task automatic step();
      bit e_men, e_rv, blk;
      @(posedge clk);
      #1;
      cyc++;
      e_men = (cyc == gnt_cyc);
      e_rv  = (cyc == gnt_cyc + LAT + 1);
      chk("if_gnt", 32'(if_gnt), 32'(e_men && !win_dm));
      chk("dm_gnt", 32'(dm_gnt), 32'(e_men && win_dm));
      chk("mem_en", 32'(mem_en), 32'(e_men));
      chk("busy", 32'(busy), 32'(cyc >= gnt_cyc && cyc <= gnt_cyc + LAT + 1));
      if (e_men) begin
         chk("mem_addr", mem_addr, t_addr);
         chk("mem_we", 32'(mem_we), 32'(t_we));
         if (t_we) chk("mem_wdata", mem_wdata, t_wdata);
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(e_rv && !win_dm));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(e_rv && win_dm));
      if (e_rv) begin
         if (win_dm) chk("dm_rdata", dm_rdata, t_rdata);
         else        chk("if_rdata", if_rdata, t_rdata);
      end

      // memory model answers whatever the DUT puts on the bus
      if (mem_en) begin
         resp_data = bus_rd(mem_addr);
         if (mem_we) bus_mem[mem_addr] = mem_wdata;
         resp_cyc = cyc + LAT;
      end

      if (rst_left > 0) begin
         rst_left--;
         if (rst_left == 0) begin
            reset = 1'b0;
            next_idle = cyc;
         end
      end else if (gnt_cyc >= 0 && cyc == gnt_cyc + 1 &&
                   (force_rst || $urandom_range(0, 99) < p_rst)) begin
         force_rst = 1'b0;
         reset = 1'b1;
         #1;
         chk_zero();
         if (win_dm) begin
            dm_pend = 1'b1; dm_we_r = t_we; dm_a = t_addr; dm_d = t_wdata;
         end else begin
            if_pend = 1'b1; if_a = t_addr;
         end
         gnt_cyc  = -100;
         starve   = 0;
         last_dm  = 1'b0;
         rst_left = $urandom_range(1, 3);
      end

      // the owner of an outstanding access does not post a new one before its response
      blk = (cyc < gnt_cyc + LAT + 1);
      if (!if_pend && !(blk && !win_dm) && $urandom_range(0, 99) < p_if) begin
         if_pend = 1'b1; if_a = rand_addr();
      end
      if (!dm_pend && !(blk && win_dm) && $urandom_range(0, 99) < p_dm) begin
         dm_pend = 1'b1; dm_a = rand_addr(); dm_d = $urandom();
         dm_we_r = ($urandom_range(0, 99) < p_we);
      end
      if_req    = if_pend;
      if_addr   = if_pend ? if_a : $urandom();
      dm_req    = dm_pend;
      dm_we     = dm_pend ? dm_we_r : 1'($urandom());
      dm_addr   = dm_pend ? dm_a : $urandom();
      dm_wdata  = dm_pend ? dm_d : $urandom();
      mem_rdata = (cyc == resp_cyc) ? resp_data : $urandom();

      if (!reset && cyc == next_idle) begin
         if (if_pend || dm_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
            win_dm = (if_pend && dm_pend) ? !last_dm : dm_pend;
`else
            win_dm = dm_pend && !(if_pend && starve == STARVE);
            if (!win_dm)      starve = 0;
            else if (if_pend) starve++;
`endif
            last_dm = win_dm;
            if (win_dm) begin
               t_we = dm_we_r; t_addr = dm_a; t_wdata = dm_d;
               t_rdata = dm_we_r ? 32'd0 : ref_rd(dm_a);
               if (dm_we_r) ref_mem[dm_a] = dm_d;
               dm_pend = 1'b0;
            end else begin
               t_we = 1'b0; t_addr = if_a; t_wdata = 32'd0;
               t_rdata = ref_rd(if_a);
               if_pend = 1'b0;
            end
            gnt_cyc   = cyc + 1;
            next_idle = cyc + LAT + 3;
         end else begin
            next_idle = cyc + 1;
         end
      end
   endtask

   initial begin
      logic [31:0] r1_data;
      bit          r1_arm;
      if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
      mem_rdata = '0;
      if_req1 = 1'b0; if_addr1 = '0; dm_req1 = 1'b0; dm_we1 = 1'b0; dm_addr1 = '0; dm_wdata1 = '0;
      mem_rdata1 = '0;
      p_if = 0; p_dm = 0; p_we = 0; p_rst = 0; force_rst = 1'b0;
      starve = 0; last_dm = 1'b0; win_dm = 1'b0;
      ref_mem[32'h40] = 32'h8C010004;
      bus_mem[32'h40] = 32'h8C010004;

      // fetch posted during reset, serviced once reset drops
      if_pend = 1'b1; if_a = 32'h40;
      rst_left = 3;
      repeat (10) step();

      dm_pend = 1'b1; dm_we_r = 1'b1; dm_a = 32'h200; dm_d = 32'hDEADBEEF;
      repeat (8) step();

      if_pend = 1'b1; if_a = 32'h104;
      dm_pend = 1'b1; dm_we_r = 1'b0; dm_a = 32'h100;
      repeat (14) step();

      dm_pend = 1'b1; dm_we_r = 1'b0; dm_a = 32'h200;
      repeat (7) step();

      // load dropped by reset in its wait cycle, then re-granted
      dm_pend = 1'b1; dm_we_r = 1'b0; dm_a = 32'h100; force_rst = 1'b1;
      repeat (18) step();

      p_if = 100; p_dm = 100; p_we = 30;
      repeat (80) step();

      p_if = 40; p_dm = 50; p_we = 40; p_rst = 8;
      repeat (600) step();

      p_if = 0; p_dm = 0; p_rst = 0;
      repeat (12) step();
      if_req = 1'b0; dm_req = 1'b0;

      // MEM_LAT = 1 instance: back-to-back fetches, one every 4 cycles
      r1_arm = 1'b0; r1_data = '0;
      for (int j = 0; j < 26; j++) begin
         @(posedge clk);
         #1;
         chk("l1_if_gnt", 32'(if_gnt1), 32'(j % 4 == 1));
         chk("l1_dm_gnt", 32'(dm_gnt1), 32'd0);
         chk("l1_mem_en", 32'(mem_en1), 32'(j % 4 == 1));
         chk("l1_busy", 32'(busy1), 32'(j % 4 != 0));
         if (j % 4 == 1) begin
            chk("l1_mem_addr", mem_addr1, 32'h1000 + 32'(4 * (j / 4)));
            chk("l1_mem_we", 32'(mem_we1), 32'd0);
         end
         chk("l1_if_rvalid", 32'(if_rvalid1), 32'(j % 4 == 3));
         if (j % 4 == 3)
            chk("l1_if_rdata", if_rdata1, init_word(32'h1000 + 32'(4 * (j / 4))));
         mem_rdata1 = r1_arm ? r1_data : $urandom();
         r1_arm  = mem_en1;
         r1_data = init_word(mem_addr1);
         if_req1  = 1'b1;
         if_addr1 = 32'h1000 + 32'(4 * ((j + 3) / 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
